bk_sector_seq: RTL
==================

Name: bk_sector_seq

Overview:
- Parametrised backup-RAM / save-state sequencer. Moves a slot-sized region of on-chip NVRAM to and from the mounted save image, one SD sector at a time, over the hps_io sd_lba/sd_rd/sd_wr/sd_ack handshake.
- Generalises the fixed 64-sector, 4-slot save/load logic in the emu top level. Adds configurable slot and sector counts, an ack timeout with an error flag, and dirty tracking with an autosave trigger.
- Sits in emu, between the status/OSD bits, hps_io, and the NVRAM dpram port B. The dpram address is {sector index, sd_buff_addr}.

Parameters:
- SECTOR_BITS, 6: log2 of sectors per slot; slot size = 2^SECTOR_BITS × 512 bytes.
- SLOT_BITS, 2: log2 of the number of save slots.
- ACK_TIMEOUT, 2^24: clk_sys cycles to wait for an sd_ack rising edge before aborting.
- AUTOSAVE, 1: when 1, autosave_req is honoured; when 0, it is ignored.

Ports:
- clk_sys, in, 1: system clock.
- RESET_n, in, 1: asynchronous active-low reset.
- bk_ena, in, 1: a save image is mounted and writable.
- load_req, in, 1: level; its rising edge requests a load.
- save_req, in, 1: level; its rising edge requests a save.
- autosave_req, in, 1: single-cycle pulse requesting a save only if the region is dirty.
- slot, in, SLOT_BITS: slot selection, latched when an operation starts.
- dirty_set, in, 1: pulse on every NVRAM write from the system.
- sd_lba, out, 32: sector address = {slot_latched, sector_idx}, zero-extended.
- sd_rd, out, 1: read request to hps_io.
- sd_wr, out, 1: write request to hps_io.
- sd_ack, in, 1: hps_io transfer acknowledge.
- sector_idx, out, SECTOR_BITS: current sector; drives the upper dpram address bits.
- busy, out, 1: an operation is in progress.
- loading, out, 1: a load is in progress; the top level ORs this into system reset.
- done, out, 1: one-cycle pulse when an operation completes successfully.
- err, out, 1: sticky; set by a timeout, cleared when the next operation starts.
- dirty, out, 1: NVRAM differs from the image.

Behaviour:
- Reset values: all outputs 0; state IDLE; edge-detect registers 0; timeout counter 0.
- Edge detect: registers hold the previous values of load_req & bk_ena and save_req & bk_ena. A request is a 0→1 transition of either gated signal.
- Edges that arrive outside IDLE are consumed and dropped, never queued.
- States: IDLE, REQ, XFER.
- IDLE → REQ on a load edge, a save edge, or (AUTOSAVE && autosave_req && dirty && bk_ena).
  - Priority: load > save > autosave.
  - On entry: latch slot and the operation, sector_idx←0, err←0, timeout counter←0.
  - Assert sd_rd=1 for a load or sd_wr=1 for a save, registered in the same cycle as the transition.
  - A save start (manual or auto) clears dirty in the entry cycle. A dirty_set in that same cycle wins, so dirty stays 1.
- REQ:
  - Hold sd_rd/sd_wr. The timeout counter increments every cycle.
  - On an sd_ack rising edge (registered previous ack): drop sd_rd and sd_wr to 0, clear the counter, go to XFER.
  - If the counter reaches ACK_TIMEOUT-1 first: drop rd/wr, set err=1, go to IDLE. loading drops and done is not pulsed. A save that times out sets dirty=1.
- XFER: wait for the sd_ack falling edge (no timeout here, since hps_io always completes a granted transfer).
  - If sector_idx is all ones: go to IDLE, done=1 for one cycle.
    - Load: dirty←0, except that a dirty_set in the same cycle wins.
    - Save: dirty unchanged.
  - Otherwise: sector_idx+1, go to REQ, reassert the same rd/wr, clear the counter.
- sd_ack high already on REQ entry: no edge yet; keep waiting for a fresh rising edge.
- busy = (state != IDLE). loading = busy && op==load.
- sd_lba is valid throughout REQ/XFER. It holds its last value in IDLE.
- bk_ena is sampled only at start; a drop mid-operation does not abort.
- Slot changes mid-operation are ignored.
- dirty_set is accepted in every state. During a save it re-marks the region dirty.
- sector_idx does not wrap within an operation. Completion is detected on all-ones before any increment.
- RESET_n low mid-operation returns to IDLE immediately with all outputs 0. The hps_io transfer in flight is orphaned, and its stale ack falling edge is ignored because the state is IDLE.

Test Plan:
- Load, slot=2, SECTOR_BITS=6, bk_ena=1; model acks each request 3 cycles later for 5 cycles → 64 sd_rd pulses; sd_lba 0x80..0xBF; loading=1 throughout; single done pulse; busy=0 afterwards.
- Save, slot=1, dirty=1 → dirty clears at start; 64 sd_wr requests, lba 0x40..0x7F; a dirty_set injected at sector 10 leaves dirty=1 at done.
- Timeout with ACK_TIMEOUT=100 and no sd_ack → sd_rd high for exactly 100 cycles then 0; err=1; busy=0; no done. A following save edge clears err.
- Load and save edges in the same cycle → load executes; a save edge during the load is dropped (no sd_wr after done).
- autosave_req with dirty=0 → no activity. With dirty=1 → full save. With AUTOSAVE=0 → no activity.
- RESET_n asserted at sector 30 of a load → outputs 0 asynchronously. After release, a new load starts at lba {slot,0}, ignoring the old ack falling edge.

Source files
------------

// File: rtl/bk_sector_seq.sv
// Backup-RAM / save-state sequencer: streams one slot of NVRAM to or from the
// mounted save image one SD sector at a time over the hps_io handshake.
module bk_sector_seq #(
  parameter int SECTOR_BITS = 6,
  parameter int SLOT_BITS   = 2,
  parameter int ACK_TIMEOUT = 1 << 24,
  parameter bit AUTOSAVE    = 1'b1
) (
  input  logic                   clk_sys,
  input  logic                   RESET_n,
  input  logic                   bk_ena,
  input  logic                   load_req,
  input  logic                   save_req,
  input  logic                   autosave_req,
  input  logic [SLOT_BITS-1:0]   slot,
  input  logic                   dirty_set,
  output logic [31:0]            sd_lba,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  output logic [SECTOR_BITS-1:0] sector_idx,
  output logic                   busy,
  output logic                   loading,
  output logic                   done,
  output logic                   err,
  output logic                   dirty
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_XFER
  } state_e;

  state_e                 state_q;
  logic                   load_prev_q;
  logic                   save_prev_q;
  logic                   ack_q;
  logic                   op_load_q;
  logic [SLOT_BITS-1:0]   slot_q;
  logic [SECTOR_BITS-1:0] sector_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rd_q;
  logic                   wr_q;
  logic                   done_q;
  logic                   err_q;
  logic                   dirty_q;

  logic load_lvl_d;
  logic save_lvl_d;
  logic load_edge_d;
  logic save_edge_d;
  logic auto_start_d;
  logic ack_rise_d;
  logic ack_fall_d;

  assign load_lvl_d   = load_req & bk_ena;
  assign save_lvl_d   = save_req & bk_ena;
  assign load_edge_d  = load_lvl_d & ~load_prev_q;
  assign save_edge_d  = save_lvl_d & ~save_prev_q;
  assign auto_start_d = AUTOSAVE && autosave_req && dirty_q && bk_ena;
  assign ack_rise_d   = sd_ack & ~ack_q;
  assign ack_fall_d   = ~sd_ack & ack_q;

  // NOTE: every register below is updated with <= so all next-state terms see
  // the pre-edge values; a blocking = here would create order-dependent logic.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= S_IDLE;
      load_prev_q <= 1'b0;
      save_prev_q <= 1'b0;
      ack_q       <= 1'b0;
      op_load_q   <= 1'b0;
      slot_q      <= '0;
      sector_q    <= '0;
      cnt_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      dirty_q     <= 1'b0;
    end else begin
      load_prev_q <= load_lvl_d;
      save_prev_q <= save_lvl_d;
      ack_q       <= sd_ack;
      done_q      <= 1'b0;
      if (dirty_set) dirty_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (load_edge_d || save_edge_d || auto_start_d) begin
            state_q   <= S_REQ;
            op_load_q <= load_edge_d;
            slot_q    <= slot;
            sector_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_q      <= load_edge_d;
            wr_q      <= ~load_edge_d;
            // A save snapshots the region, so a concurrent write keeps it dirty.
            if (!load_edge_d) dirty_q <= dirty_set;
          end
        end

        S_REQ: begin
          if (ack_rise_d) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_XFER;
          end else if (cnt_q == CNT_LAST) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_IDLE;
            if (!op_load_q) dirty_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_XFER: begin
          if (ack_fall_d) begin
            if (&sector_q) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              if (op_load_q) dirty_q <= dirty_set;
            end else begin
              sector_q <= sector_q + SECTOR_BITS'(1);
              cnt_q    <= '0;
              rd_q     <= op_load_q;
              wr_q     <= ~op_load_q;
              state_q  <= S_REQ;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sd_lba     = 32'({slot_q, sector_q});
  assign sd_rd      = rd_q;
  assign sd_wr      = wr_q;
  assign sector_idx = sector_q;
  assign busy       = (state_q != S_IDLE);
  assign loading    = busy && op_load_q;
  assign done       = done_q;
  assign err        = err_q;
  assign dirty      = dirty_q;

endmodule
